user_mailbox: RTL and testbench

OBI subordinate on the user-domain demultiplexer that lets software pass 32-bit words through a hardware FIFO and raises an interrupt at a programmable fill level. It occupies one user address region, behind `obi_demux` alongside the user ROM and error subordinate. Its `irq_o` drives one bit of the user domain's `interrupts_o`.

---
 rtl/user_mailbox.sv | 214 +++++++++++++++++++++
 tb/tb_user_mailbox.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_mailbox.sv
// ----------------------------------------------------------------------------
// user_mailbox
//
// OBI subordinate that lets software pass 32-bit words through a hardware
// FIFO. A level interrupt is raised once the FIFO fill level reaches a
// programmable threshold (when enabled).
//
// Register map (word offset addr[3:2], all other address bits ignored):
//   0x0 DATA   : write pushes wdata, read pops the head entry
//   0x4 STATUS : [15:0] count, [16] empty, [17] full,
//                [18] sticky overflow, [19] sticky underflow (read-only)
//   0x8 THRESH : [7:0] interrupt threshold (written when be[0]=1)
//   0xC CTRL   : [0] irq_en (written when be[0]=1), [1] flush (write-1),
//                [2] clear_sticky (write-1)
//
// Ports:
//   clk_i     : clock, all state updates on the rising edge
//   rst_i     : synchronous active-high reset
//   obi_req_i : OBI request (req, a.addr, a.we, a.be, a.wdata, a.aid)
//   obi_rsp_o : OBI response (gnt, rvalid, r.rdata, r.rid, r.err)
//   irq_o     : registered level interrupt
// ----------------------------------------------------------------------------

package user_mailbox_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t SbrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        sbr_obi_r_chan_t r;
        logic            gnt;
        logic            rvalid;
    } sbr_obi_rsp_t;

endpackage

module user_mailbox #(
    parameter user_mailbox_pkg::obi_cfg_t ObiCfg = user_mailbox_pkg::SbrObiCfg,
    parameter type obi_req_t = user_mailbox_pkg::sbr_obi_req_t,
    parameter type obi_rsp_t = user_mailbox_pkg::sbr_obi_rsp_t,
    parameter int unsigned Depth = 8
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     irq_o
);

    localparam int unsigned DataWidth = ObiCfg.DataWidth;
    localparam int unsigned PtrW      = $clog2(Depth);
    localparam int unsigned CntW      = $clog2(Depth) + 1;

    localparam logic [1:0] OffData   = 2'd0;
    localparam logic [1:0] OffStatus = 2'd1;
    localparam logic [1:0] OffThresh = 2'd2;
    localparam logic [1:0] OffCtrl   = 2'd3;

    logic [DataWidth-1:0] mem [Depth];

    logic [PtrW-1:0] rd_ptr, rd_ptr_next;
    logic [PtrW-1:0] wr_ptr, wr_ptr_next;
    logic [CntW-1:0] count, count_next;
    logic [7:0]      threshold, threshold_next;
    logic            irq_en, irq_en_next;
    logic            overflow, overflow_next;
    logic            underflow, underflow_next;
    logic            irq_q, irq_next;
    obi_rsp_t        rsp_q;

    logic                 accept;
    logic [1:0]           offset;
    logic                 empty, full;
    logic                 push_ok, pop_ok;
    logic                 push_err, pop_err;
    logic                 flush, clear_sticky;
    logic [DataWidth-1:0] rdata_d;

    // Only the word offset and the low byte enable carry meaning here.
    logic unused_req_bits;
    assign unused_req_bits = ^{obi_req_i.a.addr[$bits(obi_req_i.a.addr)-1:4],
                               obi_req_i.a.addr[1:0],
                               obi_req_i.a.be[$bits(obi_req_i.a.be)-1:1]};

    // Decode the request and work out every next-state value. A request seen
    // while reset is high is granted but must leave no trace, so acceptance
    // is gated by reset. Read data is formed from the pre-edge state.
    always_comb begin
        accept         = obi_req_i.req & ~rst_i;
        offset         = obi_req_i.a.addr[3:2];
        empty          = (count == '0);
        full           = (count == CntW'(Depth));

        push_ok        = accept &  obi_req_i.a.we & (offset == OffData) & ~full;
        push_err       = accept &  obi_req_i.a.we & (offset == OffData) &  full;
        pop_ok         = accept & ~obi_req_i.a.we & (offset == OffData) & ~empty;
        pop_err        = accept & ~obi_req_i.a.we & (offset == OffData) &  empty;
        flush          = accept &  obi_req_i.a.we & (offset == OffCtrl) & obi_req_i.a.wdata[1];
        clear_sticky   = accept &  obi_req_i.a.we & (offset == OffCtrl) & obi_req_i.a.wdata[2];

        rd_ptr_next    = rd_ptr;
        wr_ptr_next    = wr_ptr;
        count_next     = count;
        threshold_next = threshold;
        irq_en_next    = irq_en;
        overflow_next  = overflow  | push_err;
        underflow_next = underflow | pop_err;

        if (push_ok) begin
            wr_ptr_next = wr_ptr + PtrW'(1);
            count_next  = count + CntW'(1);
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr + PtrW'(1);
            count_next  = count - CntW'(1);
        end
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end
        if (clear_sticky) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end

        if (accept && obi_req_i.a.we && obi_req_i.a.be[0]) begin
            if (offset == OffThresh) threshold_next = obi_req_i.a.wdata[7:0];
            if (offset == OffCtrl)   irq_en_next    = obi_req_i.a.wdata[0];
        end

        irq_next = irq_en_next & (32'(count_next) >= 32'(threshold_next));

        rdata_d = '0;
        if (accept && !obi_req_i.a.we) begin
            case (offset)
                OffData:   rdata_d = pop_ok ? mem[rd_ptr] : '0;
                OffStatus: rdata_d = DataWidth'({12'b0, underflow, overflow, full, empty, 16'(count)});
                OffThresh: rdata_d = DataWidth'(threshold);
                default:   rdata_d = DataWidth'(irq_en);
            endcase
        end
    end

    // Control state, the registered interrupt and the one-cycle response.
    // Reset also kills a response that would otherwise appear this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            threshold <= 8'd1;
            irq_en    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            irq_q     <= 1'b0;
            rsp_q     <= '0;
        end else begin
            rd_ptr         <= rd_ptr_next;
            wr_ptr         <= wr_ptr_next;
            count          <= count_next;
            threshold      <= threshold_next;
            irq_en         <= irq_en_next;
            overflow       <= overflow_next;
            underflow      <= underflow_next;
            irq_q          <= irq_next;
            rsp_q.gnt      <= 1'b0;
            rsp_q.rvalid   <= accept;
            rsp_q.r.rdata  <= rdata_d;
            rsp_q.r.err    <= push_err | pop_err;
            rsp_q.r.rid    <= obi_req_i.a.aid;
        end
    end

    // FIFO storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= obi_req_i.a.wdata[DataWidth-1:0];
        end
    end

    // Grant follows the request combinationally; everything else is registered.
    always_comb begin
        obi_rsp_o     = rsp_q;
        obi_rsp_o.gnt = obi_req_i.req;
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_user_mailbox.sv
// ----------------------------------------------------------------------------
// tb_user_mailbox
//
// Self-checking bench for user_mailbox (Depth = 8). Directed steps follow the
// mailbox use cases, then a randomized phase. Expected values come from a
// queue-based reference model of the mailbox behaviour.
// ----------------------------------------------------------------------------

module tb_user_mailbox;

    localparam int Depth = 8;

    logic                           clk;
    logic                           rst;
    user_mailbox_pkg::sbr_obi_req_t req_s;
    user_mailbox_pkg::sbr_obi_rsp_t rsp_s;
    logic                           irq;

    int checks = 0;
    int errors = 0;

    int unsigned model_q[$];
    logic [7:0]  m_thresh;
    logic        m_irq_en;
    logic        m_ovf;
    logic        m_unf;

    user_mailbox #(
        .Depth(Depth)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .obi_req_i(req_s),
        .obi_rsp_o(rsp_s),
        .irq_o    (irq)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any miss.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model returns to its power-on state.
    task automatic model_reset();
        model_q.delete();
        m_thresh = 8'd1;
        m_irq_en = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    function automatic logic model_irq();
        return m_irq_en && (model_q.size() >= int'(m_thresh));
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = '0;
        s[15:0]  = 16'(model_q.size());
        s[16]    = (model_q.size() == 0);
        s[17]    = (model_q.size() == Depth);
        s[18]    = m_ovf;
        s[19]    = m_unf;
        return s;
    endfunction

    // One OBI transaction: present it, let the grant edge pass, then check the
    // response against the model. Consecutive calls run back-to-back.
    task automatic apply_stimulus(input string tag, input logic we, input logic [1:0] off,
                                  input logic [31:0] wdata, input logic [3:0] be);
        logic [3:0]  aid;
        logic [31:0] addr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        aid        = 4'($urandom_range(15));
        addr       = $urandom();
        addr[3:2]  = off;
        req_s.req     = 1'b1;
        req_s.a.we    = we;
        req_s.a.addr  = addr;
        req_s.a.be    = be;
        req_s.a.wdata = wdata;
        req_s.a.aid   = aid;
        #1;
        check_output({tag, "_gnt"}, 32'(rsp_s.gnt), 32'd1);

        exp_rdata = '0;
        exp_err   = 1'b0;
        case (off)
            2'd0: begin
                if (we) begin
                    if (model_q.size() == Depth) begin
                        exp_err = 1'b1;
                        m_ovf   = 1'b1;
                    end else begin
                        model_q.push_back(wdata);
                    end
                end else begin
                    if (model_q.size() == 0) begin
                        exp_err = 1'b1;
                        m_unf   = 1'b1;
                    end else begin
                        exp_rdata = model_q.pop_front();
                    end
                end
            end
            2'd1: begin
                if (!we) exp_rdata = model_status();
            end
            2'd2: begin
                if (!we)        exp_rdata = 32'(m_thresh);
                else if (be[0]) m_thresh  = wdata[7:0];
            end
            default: begin
                if (!we) begin
                    exp_rdata = 32'(m_irq_en);
                end else begin
                    if (be[0])    m_irq_en = wdata[0];
                    if (wdata[1]) model_q.delete();
                    if (wdata[2]) begin
                        m_ovf = 1'b0;
                        m_unf = 1'b0;
                    end
                end
            end
        endcase

        @(posedge clk);
        #1;
        req_s.req = 1'b0;
        check_output({tag, "_rvalid"}, 32'(rsp_s.rvalid), 32'd1);
        check_output({tag, "_rdata"},  rsp_s.r.rdata,      exp_rdata);
        check_output({tag, "_err"},    32'(rsp_s.r.err),   32'(exp_err));
        check_output({tag, "_rid"},    32'(rsp_s.r.rid),   32'(aid));
        check_output({tag, "_irq"},    32'(irq),           32'(model_irq()));
    endtask

    // An idle cycle must produce no response and leave the interrupt steady.
    task automatic idle_cycle(input string tag);
        req_s.req = 1'b0;
        @(posedge clk);
        #1;
        check_output({tag, "_rvalid"}, 32'(rsp_s.rvalid), 32'd0);
        check_output({tag, "_irq"},    32'(irq),          32'(model_irq()));
    endtask

    // Directed use cases followed by a randomized mix of all accesses.
    initial begin
        req_s = '0;
        rst   = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_rvalid", 32'(rsp_s.rvalid),  32'd0);
        check_output("reset_rdata",  rsp_s.r.rdata,      32'd0);
        check_output("reset_err",    32'(rsp_s.r.err),   32'd0);
        check_output("reset_rid",    32'(rsp_s.r.rid),   32'd0);
        check_output("reset_irq",    32'(irq),           32'd0);
        check_output("reset_gnt",    32'(rsp_s.gnt),     32'd0);
        rst = 1'b0;
        idle_cycle("idle0");

        // Basic order, interrupt disabled
        apply_stimulus("push_11", 1'b1, 2'd0, 32'h11, 4'hF);
        apply_stimulus("push_22", 1'b1, 2'd0, 32'h22, 4'hF);
        apply_stimulus("push_33", 1'b1, 2'd0, 32'h33, 4'hF);
        apply_stimulus("pop_11",  1'b0, 2'd0, 32'h0,  4'hF);
        apply_stimulus("pop_22",  1'b0, 2'd0, 32'h0,  4'hF);
        apply_stimulus("pop_33",  1'b0, 2'd0, 32'h0,  4'hF);

        // Fill to full, then overflow
        for (int i = 1; i <= Depth + 1; i++) begin
            apply_stimulus($sformatf("fill_%0d", i), 1'b1, 2'd0, 32'(i), 4'hF);
            if (i == Depth) begin
                apply_stimulus("status_full", 1'b0, 2'd1, 32'h0, 4'hF);
                check_output("status_full_const", rsp_s.r.rdata, 32'h0002_0008);
            end
        end
        apply_stimulus("status_ovf", 1'b0, 2'd1, 32'h0, 4'hF);
        check_output("status_ovf_const", rsp_s.r.rdata, 32'h0006_0008);
        for (int i = 1; i <= Depth; i++) begin
            apply_stimulus($sformatf("drain_%0d", i), 1'b0, 2'd0, 32'h0, 4'hF);
        end

        // Underflow and sticky clear
        apply_stimulus("pop_empty",   1'b0, 2'd0, 32'h0, 4'hF);
        apply_stimulus("status_unf",  1'b0, 2'd1, 32'h0, 4'hF);
        apply_stimulus("ctrl_clear",  1'b1, 2'd3, 32'h4, 4'hF);
        apply_stimulus("status_clr",  1'b0, 2'd1, 32'h0, 4'hF);
        check_output("status_clr_const", rsp_s.r.rdata, 32'h0001_0000);
        apply_stimulus("status_wr",   1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF);

        // Threshold interrupt
        apply_stimulus("thresh_3",  1'b1, 2'd2, 32'h3, 4'hF);
        apply_stimulus("ctrl_en",   1'b1, 2'd3, 32'h1, 4'hF);
        apply_stimulus("thr_push1", 1'b1, 2'd0, $urandom(), 4'hF);
        apply_stimulus("thr_push2", 1'b1, 2'd0, $urandom(), 4'hF);
        apply_stimulus("thr_push3", 1'b1, 2'd0, $urandom(), 4'hF);
        check_output("irq_rise", 32'(irq), 32'd1);
        apply_stimulus("thr_pop",   1'b0, 2'd0, 32'h0, 4'hF);
        check_output("irq_fall", 32'(irq), 32'd0);
        apply_stimulus("thresh_rd", 1'b0, 2'd2, 32'h0, 4'hF);
        apply_stimulus("ctrl_rd",   1'b0, 2'd3, 32'h0, 4'hF);
        apply_stimulus("thresh_0",  1'b1, 2'd2, 32'h0, 4'hF);
        idle_cycle("thr0_idle");
        apply_stimulus("ctrl_flush0", 1'b1, 2'd3, 32'h3, 4'hF);
        check_output("irq_thr0", 32'(irq), 32'd1);
        apply_stimulus("ctrl_off",  1'b1, 2'd3, 32'h0, 4'hF);
        apply_stimulus("thresh_1",  1'b1, 2'd2, 32'h1, 4'hF);

        // Wrap-around with alternating push/pop pairs, then flush
        for (int i = 0; i < 20; i++) begin
            apply_stimulus($sformatf("wrap_push_%0d", i), 1'b1, 2'd0,
                           {8'(i), 24'($urandom())}, 4'hF);
            apply_stimulus($sformatf("wrap_pop_%0d", i),  1'b0, 2'd0, 32'h0, 4'hF);
        end
        for (int i = 0; i < 5; i++) begin
            apply_stimulus($sformatf("pre_flush_%0d", i), 1'b1, 2'd0, $urandom(), 4'hF);
        end
        apply_stimulus("ctrl_flush",   1'b1, 2'd3, 32'h2, 4'hF);
        apply_stimulus("status_flush", 1'b0, 2'd1, 32'h0, 4'hF);
        check_output("status_flush_const", rsp_s.r.rdata, 32'h0001_0000);

        // Reset mid-stream: a granted pop loses its response
        apply_stimulus("en_irq_rst", 1'b1, 2'd3, 32'h1, 4'hF);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus($sformatf("rst_push_%0d", i), 1'b1, 2'd0, $urandom(), 4'hF);
        end
        req_s.req  = 1'b1;
        req_s.a.we = 1'b0;
        req_s.a.addr = 32'h0;
        @(posedge clk);
        #1;
        req_s.req = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_pop_rvalid", 32'(rsp_s.rvalid), 32'd0);
        check_output("rst_irq",        32'(irq),          32'd0);
        req_s.req     = 1'b1;
        req_s.a.we    = 1'b1;
        req_s.a.addr  = 32'h0;
        req_s.a.wdata = 32'hDEAD_BEEF;
        #1;
        check_output("rst_req_gnt", 32'(rsp_s.gnt), 32'd1);
        @(posedge clk);
        #1;
        req_s.req = 1'b0;
        rst       = 1'b0;
        check_output("rst_req_rvalid", 32'(rsp_s.rvalid), 32'd0);
        model_reset();
        idle_cycle("post_rst");
        apply_stimulus("status_rst", 1'b0, 2'd1, 32'h0, 4'hF);
        check_output("status_rst_const", rsp_s.r.rdata, 32'h0001_0000);

        // Randomized mix against the reference model
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 11);
            if (op <= 3)
                apply_stimulus("rnd_push", 1'b1, 2'd0, $urandom(), 4'($urandom_range(15)));
            else if (op <= 6)
                apply_stimulus("rnd_pop", 1'b0, 2'd0, $urandom(), 4'($urandom_range(15)));
            else if (op == 7)
                apply_stimulus("rnd_status", 1'b0, 2'd1, 32'h0, 4'hF);
            else if (op == 8)
                apply_stimulus("rnd_thresh", 1'b1, 2'd2, 32'($urandom_range(0, 9)),
                               4'($urandom_range(15)));
            else if (op == 9)
                apply_stimulus("rnd_ctrl", 1'b1, 2'd3,
                               ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7))
                                                           : 32'($urandom_range(0, 1)),
                               4'($urandom_range(15)));
            else if (op == 10)
                apply_stimulus("rnd_rd", 1'b0, 2'($urandom_range(2, 3)), 32'h0, 4'hF);
            else
                idle_cycle("rnd_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
